// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial unsigned adder controller. Two half adders form one full adder,
// and a carry flip-flop closes the loop around them. The operands are added
// one bit per clock, LSB first. The result {oCARRY, oSUM} = iA + iB is
// registered on the last RUN edge and announced with a one-cycle oDONE pulse.
//
// Ports:
//   iCLK    in   1      system clock, rising edge
//   iRST    in   1      asynchronous active-high reset
//   iSTART  in   1      start request, sampled only while idle
//   iA, iB  in   WIDTH  operands, latched on the accepting edge
//   oREADY  out  1      idle, a start will be accepted
//   oBUSY   out  1      serial addition in progress
//   oDONE   out  1      single-cycle pulse, result valid
//   oSUM    out  WIDTH  last completed sum (held)
//   oCARRY  out  1      last completed carry-out (held)
// ---------------------------------------------------------------------------

// Plain half adder. It is the shared datapath cell that the controller reuses
// every cycle.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oREADY,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [WIDTH-1:0] oSUM,
   output logic             oCARRY
);

   // The counter holds values 0..WIDTH, so one bit more than log2 is needed.
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   psum_q, psum_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   logic               s1, c1, s2, c2;

   // Stage 1 adds the current operand LSBs. Stage 2 folds in the carry that
   // was held over from the previous bit.
   half_adder u_ha_stage1 (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .sum   (s1),
      .carry (c1)
   );

   half_adder u_ha_stage2 (
      .a     (s1),
      .b     (carry_q),
      .sum   (s2),
      .carry (c2)
   );

   // Next-state and datapath control.
   // In RUN, the partial sum shifts right so that bit k lands in position k
   // after WIDTH shifts. The result registers are loaded from the *next*
   // partial sum and carry, so the final bit is included on the completion
   // edge itself.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (iSTART) begin
               a_d     = iA;
               b_d     = iB;
               carry_d = 1'b0;
               cnt_d   = '0;
               psum_d  = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            psum_d            = psum_q >> 1;
            psum_d[WIDTH-1]   = s2;
            carry_d           = c1 | c2;
            a_d               = a_q >> 1;
            b_d               = b_q >> 1;
            cnt_d             = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
               sum_d   = psum_d;
               cout_d  = c1 | c2;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state lives here. Reset drops any in-flight addition and clears the
   // visible result immediately.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   // Status outputs are decoded straight from the state register, so they
   // stay glitch-free and one-hot.
   assign oREADY = (state_q == IDLE);
   assign oBUSY  = (state_q == RUN);
   assign oDONE  = (state_q == DONE);
   assign oSUM   = sum_q;
   assign oCARRY = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl. It drives a WIDTH=8 instance and a
// WIDTH=1 instance from the same clock. Expected results come from constant
// vector tables or from plain (WIDTH+1)-bit addition of the operands.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic          iCLK = 1'b0;
   logic          iRST;
   logic          iSTART;
   logic [W-1:0]  iA, iB;
   logic          oREADY, oBUSY, oDONE, oCARRY;
   logic [W-1:0]  oSUM;

   logic          w1Start;
   logic [0:0]    w1A, w1B, w1Sum;
   logic          w1Ready, w1Busy, w1Done, w1Carry;

   int            checks   = 0;
   int            failures = 0;
   bit            monitorOn = 1'b0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       carry;
   } vec_t;

   vec_t vecs[6];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iSTART (iSTART),
      .iA     (iA),
      .iB     (iB),
      .oREADY (oREADY),
      .oBUSY  (oBUSY),
      .oDONE  (oDONE),
      .oSUM   (oSUM),
      .oCARRY (oCARRY)
   );

   serial_add_ctrl #(.WIDTH(1)) dutW1 (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iSTART (w1Start),
      .iA     (w1A),
      .iB     (w1B),
      .oREADY (w1Ready),
      .oBUSY  (w1Busy),
      .oDONE  (w1Done),
      .oSUM   (w1Sum),
      .oCARRY (w1Carry)
   );

   // 10 time-unit clock.
   always #5 iCLK = ~iCLK;

   // Compare one value and count the result. Any mismatch prints a FAIL line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic stepClock();
      @(posedge iCLK);
      #1;
   endtask

   // Status outputs must be one-hot on every cycle outside reset.
   always @(negedge iCLK) begin
      if (monitorOn && !iRST) begin
         checkOutput("onehot_w8", 32'($countones({oREADY, oBUSY, oDONE})), 1);
         checkOutput("onehot_w1", 32'($countones({w1Ready, w1Busy, w1Done})), 1);
      end
   end

   // Wait, with a bound, until the WIDTH=8 instance is idle.
   task automatic waitReady();
      int n;
      n = 0;
      while (!oREADY && n < 50) begin
         stepClock();
         n++;
      end
      checkOutput("ready_wait", oREADY, 1);
   endtask

   // Accept one addition and wait for its done pulse. The operands are
   // scrambled right after the accept to show they are no longer needed.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                output int edges, output bit seen);
      waitReady();
      iA     = a;
      iB     = b;
      iSTART = 1'b1;
      stepClock();
      iSTART = 1'b0;
      iA     = 8'($urandom);
      iB     = 8'($urandom);
      edges  = 1;
      seen   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (oDONE) begin
            seen = 1'b1;
            break;
         end
         stepClock();
         edges++;
      end
   endtask

   // Run one addition and compare the result, latency and pulse shape.
   task automatic runAndCheck(input string name, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] expSum,
                              input logic expCarry);
      int edges;
      bit seen;
      applyStimulus(a, b, edges, seen);
      checkOutput({name, "_done_seen"}, seen, 1);
      checkOutput({name, "_latency"}, edges, W + 1);
      checkOutput({name, "_sum"}, oSUM, expSum);
      checkOutput({name, "_carry"}, oCARRY, expCarry);
      stepClock();
      checkOutput({name, "_pulse_end"}, oDONE, 0);
      checkOutput({name, "_ready_back"}, oREADY, 1);
      checkOutput({name, "_sum_hold"}, oSUM, expSum);
   endtask

   // Main sequence: reset, table vectors, random vectors, then the
   // multi-cycle corner cases.
   initial begin
      logic [8:0] model;
      logic [7:0] ra, rb;
      logic [1:0] m1;
      int         doneCount;
      int         n;

      vecs[0] = '{a: 8'hA5, b: 8'h3C, sum: 8'hE1, carry: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1};
      vecs[3] = '{a: 8'h10, b: 8'h20, sum: 8'h30, carry: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1};
      vecs[5] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0};

      // Reset with random inputs toggling underneath.
      iRST    = 1'b1;
      w1Start = 1'b0;
      w1A     = 1'b0;
      w1B     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iSTART = 1'($urandom);
         iA     = 8'($urandom);
         iB     = 8'($urandom);
         w1Start = 1'($urandom);
         stepClock();
      end
      checkOutput("rst_ready", oREADY, 1);
      checkOutput("rst_busy", oBUSY, 0);
      checkOutput("rst_done", oDONE, 0);
      checkOutput("rst_sum", oSUM, 0);
      checkOutput("rst_carry", oCARRY, 0);
      checkOutput("rst_w1_ready", w1Ready, 1);
      iSTART  = 1'b0;
      w1Start = 1'b0;
      iRST    = 1'b0;
      monitorOn = 1'b1;
      stepClock();

      $display("[TB] table vectors");
      for (int i = 0; i < 6; i++) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].sum, vecs[i].carry);
      end

      $display("[TB] random vectors");
      for (int i = 0; i < 20; i++) begin
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         model = {1'b0, ra} + {1'b0, rb};
         runAndCheck($sformatf("rand%0d", i), ra, rb, model[7:0], model[8]);
      end

      // A start pulse during RUN must be ignored, not queued.
      $display("[TB] start while busy");
      waitReady();
      iA = 8'h10; iB = 8'h20; iSTART = 1'b1;
      stepClock();
      iSTART = 1'b0;
      stepClock();
      stepClock();
      iA = 8'h01; iB = 8'h01; iSTART = 1'b1;
      stepClock();
      iSTART = 1'b0;
      n = 0;
      while (!oDONE && n < 40) begin
         stepClock();
         n++;
      end
      checkOutput("busy_start_done_seen", oDONE, 1);
      checkOutput("busy_start_sum", oSUM, 8'h30);
      checkOutput("busy_start_carry", oCARRY, 0);
      stepClock();
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         if (oDONE) doneCount++;
         stepClock();
      end
      checkOutput("busy_start_no_second_done", doneCount, 0);
      checkOutput("busy_start_sum_hold", oSUM, 8'h30);

      // Reset mid-operation clears the result asynchronously and drops the
      // in-flight add.
      $display("[TB] reset mid-operation");
      waitReady();
      iA = 8'h7F; iB = 8'h01; iSTART = 1'b1;
      stepClock();
      iSTART = 1'b0;
      stepClock();
      stepClock();
      stepClock();
      checkOutput("midrst_busy_before", oBUSY, 1);
      #2;
      iRST = 1'b1;
      #1;
      checkOutput("midrst_async_ready", oREADY, 1);
      checkOutput("midrst_async_busy", oBUSY, 0);
      checkOutput("midrst_async_sum", oSUM, 0);
      checkOutput("midrst_async_carry", oCARRY, 0);
      stepClock();
      iRST = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 12; i++) begin
         if (oDONE) doneCount++;
         stepClock();
      end
      checkOutput("midrst_no_done", doneCount, 0);
      runAndCheck("after_rst", 8'h02, 8'h03, 8'h05, 1'b0);

      // With iSTART held high, every idle cycle is immediately an accept.
      $display("[TB] back-to-back");
      iSTART = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         model = {1'b0, ra} + {1'b0, rb};
         iA = ra;
         iB = rb;
         checkOutput($sformatf("b2b%0d_ready", k), oREADY, 1);
         stepClock();
         checkOutput($sformatf("b2b%0d_accept", k), oBUSY, 1);
         n = 1;
         while (!oDONE && n < 40) begin
            stepClock();
            n++;
         end
         checkOutput($sformatf("b2b%0d_latency", k), n, W + 1);
         checkOutput($sformatf("b2b%0d_sum", k), oSUM, model[7:0]);
         checkOutput($sformatf("b2b%0d_carry", k), oCARRY, model[8]);
         stepClock();
      end
      iSTART = 1'b0;
      waitReady();

      // WIDTH=1: two-edge latency, carry-out carries the real information.
      $display("[TB] width 1");
      for (int c = 0; c < 4; c++) begin
         m1 = 2'(c[1]) + 2'(c[0]);
         w1A = c[1];
         w1B = c[0];
         w1Start = 1'b1;
         stepClock();
         w1Start = 1'b0;
         w1A = 1'($urandom);
         w1B = 1'($urandom);
         checkOutput($sformatf("w1_%0d_edge0_no_done", c), w1Done, 0);
         stepClock();
         checkOutput($sformatf("w1_%0d_done", c), w1Done, 1);
         checkOutput($sformatf("w1_%0d_sum", c), w1Sum, m1[0]);
         checkOutput($sformatf("w1_%0d_carry", c), w1Carry, m1[1]);
         stepClock();
         checkOutput($sformatf("w1_%0d_pulse_end", c), w1Done, 0);
         checkOutput($sformatf("w1_%0d_ready", c), w1Ready, 1);
      end

      monitorOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
